dbg_trace_buffer: RTL
=====================

# dbg_trace_buffer

Parametrised debug trace buffer for the single-cycle MIPS core. Each enabled cycle it samples CH packed datapath channels, such as PC, instruction and ALU result, into a circular buffer of DEPTH entries. It captures pre-trigger history, then a programmable number of post-trigger samples. Software or the bench then reads the capture out oldest-first through a simple request/valid port. It is the successor to the fixed, monitor-only datapath debug view: it adds trigger modes, history depth and stored readout.

## Interface
- DATA_W, 32, width of one channel
- CH, 3, number of channels; channel 0 is the trigger-compare channel
- DEPTH, 16, buffer entries; power of 2, ≥4
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  pulse; starts a new capture (honoured only in IDLE or DONE)
- trig_mode  in  2  00 immediate, 01 ch0==trig_val, 10 (ch0&trig_mask)==(trig_val&trig_mask), 11 trig_ext
- trig_val  in  DATA_W  compare value
- trig_mask  in  DATA_W  compare mask (mode 10 only)
- trig_ext  in  1  external trigger, qualified by smp_valid
- post_cnt  in  $clog2(DEPTH)+1  samples stored from the trigger onward, trigger sample included; 0 is treated as 1, values >DEPTH clip to DEPTH
- smp_valid  in  1  sample enable
- smp_data  in  CH*DATA_W  packed channels, ch0 in [DATA_W-1:0]
- rd_req  in  1  readout request
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  CH*DATA_W  read entry
- rd_last  out  1  marks final entry, coincident with rd_valid
- state  out  2  00 IDLE, 01 PRE, 10 POST, 11 DONE
- fill_cnt  out  $clog2(DEPTH)+1  stored entries, saturates at DEPTH
- wrapped  out  1  pre-trigger history was overwritten

## Operation
- **Reset.** rst clears state to IDLE and sets wr_ptr, fill_cnt, post_left, rd_ptr, rd_left, rd_valid, rd_last and wrapped to 0. rd_data resets to 0. Buffer contents are not reset.
- **IDLE.**
  - arm: go to PRE, clear wr_ptr, fill_cnt and wrapped, latch post_cnt (after the 0/clip rule).
  - smp_valid and rd_req are ignored.
- **PRE.**
  - On smp_valid: write smp_data at wr_ptr, advance wr_ptr mod DEPTH, fill_cnt += 1 saturating.
  - Writing when fill_cnt==DEPTH sets wrapped.
  - Trigger is evaluated on the same sample and modes are evaluated combinationally. Mode 00 fires on the first valid sample.
  - On trigger: post_left = latched_post−1. If post_left==0, go to DONE; otherwise go to POST.
- **POST.**
  - On smp_valid: write as in PRE, post_left −= 1.
  - When the write makes post_left 0, go to DONE.
  - The trigger logic is inactive in POST.
- **DONE.**
  - On entry: rd_ptr = (wr_ptr − fill_cnt) mod DEPTH, rd_left = fill_cnt.
  - rd_req with rd_left>0: the next cycle returns the entry, with rd_valid=1. Then rd_ptr advances and rd_left decrements.
  - rd_last=1 when the returned entry was rd_left==1.
  - The cycle after rd_last, state returns to IDLE. fill_cnt holds until the next arm.
  - smp_valid is ignored in DONE.
- **Simultaneous events.**
  - arm in PRE or POST is ignored.
  - arm and rd_req together in DONE: arm wins. The readout is aborted, rd_valid is low next cycle, and state goes to PRE.
- **Storage.** Channels are stored unmodified; there is no arithmetic on data. Pointers wrap modulo DEPTH.

## Timing
- Write latency: the sample is in the buffer at the edge where smp_valid=1.
- State changes on the edge that samples the triggering or last post sample. state reads DONE in the following cycle.
- Read latency: 1 cycle from rd_req to rd_valid. rd_req held high gives one entry per cycle.
- Bubbles: rd_valid is a registered pulse per accepted request. Gaps in rd_req produce gaps in rd_valid, with no loss.
- Minimum capture is 1 trigger sample with post_cnt≤1. Maximum stored is DEPTH; the oldest pre-trigger entries are dropped first.
- Asynchronous rst forces the IDLE outputs immediately, including mid-capture and mid-readout.

## Test plan
All scenarios use DEPTH=8, CH=3 and DATA_W=32; PC is ch0.
- **Immediate capture.** Mode 00, post_cnt=4, arm, feed PCs 0x0,0x4,0x8,0xC.
  - state=DONE after the 4th edge, with fill_cnt=4 and wrapped=0.
  - rd_req held gives 0x0,0x4,0x8,0xC on 4 consecutive cycles, rd_last on 0xC, then IDLE.
- **Match with wrap.** Mode 01, trig_val=0x20, post_cnt=3, feed PCs 0x00..0x40 step 4.
  - Capture stops after 0x28, with fill_cnt=8 and wrapped=1.
  - Readout gives 0x0C..0x28 in order; later samples are not stored.
- **Masked trigger, oversized post_cnt.** Mode 10, mask=0xF0, val=0x30, post_cnt=12.
  - Triggers on the first ch0 with bits[7:4]=3.
  - post_cnt clips to 8, so the readout is exactly the 8 samples starting at the trigger.
- **External trigger and gaps.** Mode 11 with smp_valid toggling 1/0.
  - trig_ext high during a smp_valid=0 cycle does not fire.
  - Only valid cycles are stored.
  - Readout holds rd_req 1-0-1 and sees rd_valid gaps with no lost entries.
- **Simultaneous arm/read.** In DONE, assert arm and rd_req together.
  - Next cycle: state=PRE, fill_cnt=0, rd_valid=0.
- **Reset mid-operation.** Assert rst during POST, then separately during readout.
  - Outputs are immediately state=0, fill_cnt=0, rd_valid=0, rd_last=0, wrapped=0.
  - After release, arm works normally.

Source files
------------

// File: rtl/dbg_trace_buffer_if.sv
// Capture/readout bundle for dbg_trace_buffer.
// The master side arms, feeds samples and requests reads. The slave side is the buffer.
interface dbg_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int CH     = 3,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 arm;
  logic [1:0]           trig_mode;
  logic [DATA_W-1:0]    trig_val;
  logic [DATA_W-1:0]    trig_mask;
  logic                 trig_ext;
  logic [CW-1:0]        post_cnt;
  logic                 smp_valid;
  logic [CH*DATA_W-1:0] smp_data;
  logic                 rd_req;
  logic                 rd_valid;
  logic [CH*DATA_W-1:0] rd_data;
  logic                 rd_last;
  logic [1:0]           state;
  logic [CW-1:0]        fill_cnt;
  logic                 wrapped;

  modport master (
    output arm, trig_mode, trig_val, trig_mask, trig_ext, post_cnt,
           smp_valid, smp_data, rd_req,
    input  rd_valid, rd_data, rd_last, state, fill_cnt, wrapped
  );

  modport slave (
    input  arm, trig_mode, trig_val, trig_mask, trig_ext, post_cnt,
           smp_valid, smp_data, rd_req,
    output rd_valid, rd_data, rd_last, state, fill_cnt, wrapped
  );
endinterface

// File: rtl/dbg_trace_buffer.sv
// Circular trace buffer. It captures pre-trigger history and post-trigger samples,
// then plays the capture back oldest-first through a request/valid port.
module dbg_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int CH     = 3,
  parameter int DEPTH  = 16
) (
  input logic               clk,
  input logic               rst,
  dbg_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CH * DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    POST = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, wr_ptr_d, rd_ptr;
  logic [CW-1:0]     fill_cnt, fill_d, post_lat, post_left, rd_left;
  logic              wrapped, rd_valid, rd_last;
  logic [SW-1:0]     rd_data;
  logic [DATA_W-1:0] ch0;
  logic              trig_hit, arm_ok, wr_en, fire, rd_go;

  // A post count of 0 still stores the trigger sample; more than DEPTH cannot be held.
  function automatic logic [CW-1:0] clip_post(input logic [CW-1:0] n);
    if (n == '0)
      return ONE_C;
    if (n > DEPTH_C)
      return DEPTH_C;
    return n;
  endfunction

  assign ch0 = bus.smp_data[DATA_W-1:0];

  always_comb begin
    trig_hit = 1'b0;
    case (bus.trig_mode)
      2'b00:   trig_hit = 1'b1;
      2'b01:   trig_hit = (ch0 == bus.trig_val);
      2'b10:   trig_hit = ((ch0 & bus.trig_mask) == (bus.trig_val & bus.trig_mask));
      default: trig_hit = bus.trig_ext;
    endcase
  end

  assign arm_ok   = bus.arm && (state_q == IDLE || state_q == DONE);
  assign wr_en    = bus.smp_valid && (state_q == PRE || state_q == POST);
  assign fire     = bus.smp_valid && (state_q == PRE) && trig_hit;
  assign rd_go    = (state_q == DONE) && !bus.arm && bus.rd_req && (rd_left != '0);
  assign wr_ptr_d = wr_ptr + AW'(1);
  assign fill_d   = (fill_cnt == DEPTH_C) ? DEPTH_C : fill_cnt + ONE_C;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.arm) state_d = PRE;
      PRE:  if (fire) state_d = (post_lat == ONE_C) ? DONE : POST;
      POST: if (bus.smp_valid && post_left == ONE_C) state_d = DONE;
      DONE: begin
        if (bus.arm)
          state_d = PRE;
        else if (rd_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= bus.smp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      post_lat  <= '0;
      post_left <= '0;
      rd_ptr    <= '0;
      rd_left   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      wrapped   <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      rd_last  <= rd_go && (rd_left == ONE_C);
      if (arm_ok) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
        wrapped  <= 1'b0;
        rd_left  <= '0;
        post_lat <= clip_post(bus.post_cnt);
      end else if (wr_en) begin
        wr_ptr   <= wr_ptr_d;
        fill_cnt <= fill_d;
        if (fill_cnt == DEPTH_C)
          wrapped <= 1'b1;
        if (fire)
          post_left <= post_lat - ONE_C;
        else if (state_q == POST)
          post_left <= post_left - ONE_C;
        // On the closing write, the readout window starts fill entries behind the new write pointer.
        if (state_d == DONE) begin
          rd_ptr  <= wr_ptr_d - fill_d[AW-1:0];
          rd_left <= fill_d;
        end
      end
      if (rd_go) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
        rd_left <= rd_left - ONE_C;
      end
    end
  end

  assign bus.state    = state_q;
  assign bus.fill_cnt = fill_cnt;
  assign bus.wrapped  = wrapped;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;
  assign bus.rd_last  = rd_last;
endmodule
